// File: rtl/multiport_regfile.sv
// Two-read / two-write register file that clears itself one register per cycle
// after reset. Define RF_BYPASS_EN to forward same-cycle write data to the read ports.
module multiport_regfile #(
    parameter int                 DATA_W   = 32,
    parameter int                 NUM_REGS = 32,
    parameter int                 AW       = $clog2(NUM_REGS),
    parameter int                 SP_IDX   = 2,
    parameter logic [DATA_W-1:0]  SP_INIT  = 32'h0000_2ffc
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [AW-1:0]     rs1,
    input  logic [AW-1:0]     rs2,
    output logic [DATA_W-1:0] rs1_dout,
    output logic [DATA_W-1:0] rs2_dout,
    input  logic              wa_en,
    input  logic [AW-1:0]     wa_rd,
    input  logic [DATA_W-1:0] wa_din,
    input  logic              wb_en,
    input  logic [AW-1:0]     wb_rd,
    input  logic [DATA_W-1:0] wb_din,
    output logic              ready,
    output logic              wr_conflict
);

    localparam logic [0:0]        ST_CLEAR  = 1'b0;
    localparam logic [0:0]        ST_READY  = 1'b1;
    localparam logic [AW-1:0]     ZERO_IDX  = {AW{1'b0}};
    localparam logic [AW-1:0]     LAST_IDX  = AW'(NUM_REGS - 1);
    localparam logic [AW-1:0]     SP_IDX_A  = AW'(SP_IDX);
    localparam logic [DATA_W-1:0] ZERO_DATA = {DATA_W{1'b0}};

    logic [0:0]        state_r;
    logic [AW-1:0]     idx_r;
    logic              wr_conflict_r;
    logic [DATA_W-1:0] regs_r [NUM_REGS];

    logic              ready_s;
    logic              wa_ok_s;
    logic              wb_ok_s;
    logic              conflict_s;
    logic [DATA_W-1:0] rs1_s;
    logic [DATA_W-1:0] rs2_s;

    // Writes are qualified by reset too, so a reset cycle never disturbs contents.
    assign ready_s    = (state_r == ST_READY);
    assign wa_ok_s    = ready_s && !reset && wa_en && (wa_rd != ZERO_IDX);
    assign wb_ok_s    = ready_s && !reset && wb_en && (wb_rd != ZERO_IDX);
    assign conflict_s = wa_ok_s && wb_ok_s && (wa_rd == wb_rd);

    // Clear sequencer and registered conflict flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= ST_CLEAR;
            idx_r         <= ZERO_IDX;
            wr_conflict_r <= 1'b0;
        end else begin
            case (state_r)
                ST_CLEAR: begin
                    idx_r <= idx_r + AW'(1);
                    if (idx_r == LAST_IDX) begin
                        state_r <= ST_READY;
                    end
                end
                ST_READY: begin
                    state_r <= ST_READY;
                end
                default: begin
                    state_r <= ST_CLEAR;
                    idx_r   <= ZERO_IDX;
                end
            endcase
            wr_conflict_r <= conflict_s;
        end
    end

    // Register storage: clear writes while clearing, otherwise ports A then B (B wins).
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state_r == ST_CLEAR) begin
                regs_r[idx_r] <= (idx_r == SP_IDX_A) ? SP_INIT : ZERO_DATA;
            end else begin
                if (wa_ok_s) begin
                    regs_r[wa_rd] <= wa_din;
                end
                if (wb_ok_s) begin
                    regs_r[wb_rd] <= wb_din;
                end
            end
        end
    end

    // Asynchronous read ports, zero until clearing completes and for x0.
    always_comb begin
        rs1_s = ZERO_DATA;
        rs2_s = ZERO_DATA;
        if (!ready_s) begin
            rs1_s = ZERO_DATA;
        end else if (rs1 == ZERO_IDX) begin
            rs1_s = ZERO_DATA;
`ifdef RF_BYPASS_EN
        end else if (wb_ok_s && (wb_rd == rs1)) begin
            rs1_s = wb_din;
        end else if (wa_ok_s && (wa_rd == rs1)) begin
            rs1_s = wa_din;
`endif
        end else begin
            rs1_s = regs_r[rs1];
        end
        if (!ready_s) begin
            rs2_s = ZERO_DATA;
        end else if (rs2 == ZERO_IDX) begin
            rs2_s = ZERO_DATA;
`ifdef RF_BYPASS_EN
        end else if (wb_ok_s && (wb_rd == rs2)) begin
            rs2_s = wb_din;
        end else if (wa_ok_s && (wa_rd == rs2)) begin
            rs2_s = wa_din;
`endif
        end else begin
            rs2_s = regs_r[rs2];
        end
    end

    assign rs1_dout    = rs1_s;
    assign rs2_dout    = rs2_s;
    assign ready       = ready_s;
    assign wr_conflict = wr_conflict_r;

endmodule

// File: tb/tb_multiport_regfile.sv
// Scoreboard bench for multiport_regfile: stimulus pushes expected outputs per cycle,
// a negedge monitor pops and compares them.
module tb_multiport_regfile;

    localparam int             DW = 32;
    localparam int             NR = 32;
    localparam int             AW = 5;
    localparam logic [DW-1:0]  SP = 32'h0000_2ffc;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [AW-1:0] rs1 = 5'd0;
    logic [AW-1:0] rs2 = 5'd0;
    logic [DW-1:0] rs1_dout;
    logic [DW-1:0] rs2_dout;
    logic          wa_en = 1'b0;
    logic [AW-1:0] wa_rd = 5'd0;
    logic [DW-1:0] wa_din = 32'd0;
    logic          wb_en = 1'b0;
    logic [AW-1:0] wb_rd = 5'd0;
    logic [DW-1:0] wb_din = 32'd0;
    logic          ready;
    logic          wr_conflict;

    always #5 clk = ~clk;

    multiport_regfile dut (
        .clk(clk), .reset(reset),
        .rs1(rs1), .rs2(rs2), .rs1_dout(rs1_dout), .rs2_dout(rs2_dout),
        .wa_en(wa_en), .wa_rd(wa_rd), .wa_din(wa_din),
        .wb_en(wb_en), .wb_rd(wb_rd), .wb_din(wb_din),
        .ready(ready), .wr_conflict(wr_conflict)
    );

    typedef struct {
        logic [DW-1:0] r1;
        logic [DW-1:0] r2;
        logic          rdy;
        logic          conf;
    } exp_t;

    exp_t          exp_q[$];
    logic [DW-1:0] model [NR];
    int            clear_steps = 0;
    logic          conf_m = 1'b0;
    int            checks = 0;
    int            failures = 0;

    // Reference: a register is visible through the read port only once clearing is done.
    function automatic logic [DW-1:0] exp_read(input logic [AW-1:0] ra);
        if (clear_steps < NR) return 32'd0;
        if (ra == 5'd0) return 32'd0;
`ifdef RF_BYPASS_EN
        if (!reset && wb_en && wb_rd != 5'd0 && wb_rd == ra) return wb_din;
        if (!reset && wa_en && wa_rd != 5'd0 && wa_rd == ra) return wa_din;
`endif
        return model[ra];
    endfunction

    // Apply the effect of one clock edge using the inputs held across it.
    task automatic model_edge();
        if (reset) begin
            clear_steps = 0;
            conf_m = 1'b0;
        end else if (clear_steps < NR) begin
            model[clear_steps] = (clear_steps == 2) ? SP : 32'd0;
            clear_steps++;
            conf_m = 1'b0;
        end else begin
            if (wa_en && wa_rd != 5'd0) model[wa_rd] = wa_din;
            if (wb_en && wb_rd != 5'd0) model[wb_rd] = wb_din;
            conf_m = wa_en && wb_en && (wa_rd == wb_rd) && (wa_rd != 5'd0);
        end
    endtask

    task automatic step(input logic r,
                        input logic ae, input logic [AW-1:0] ar, input logic [DW-1:0] ad,
                        input logic be, input logic [AW-1:0] br, input logic [DW-1:0] bd,
                        input logic [AW-1:0] q1, input logic [AW-1:0] q2);
        exp_t e;
        @(posedge clk);
        model_edge();
        #1;
        reset = r;
        wa_en = ae; wa_rd = ar; wa_din = ad;
        wb_en = be; wb_rd = br; wb_din = bd;
        rs1 = q1; rs2 = q2;
        e.r1   = exp_read(q1);
        e.r2   = exp_read(q2);
        e.rdy  = (clear_steps == NR);
        e.conf = conf_m;
        exp_q.push_back(e);
    endtask

    task automatic rand_step(input logic r, input logic narrow);
        logic [AW-1:0] ar, br;
        ar = narrow ? AW'($urandom_range(0, 3)) : AW'($urandom_range(0, NR - 1));
        br = narrow ? AW'($urandom_range(0, 3)) : AW'($urandom_range(0, NR - 1));
        step(r, 1'($urandom_range(0, 1)), ar, $urandom,
                1'($urandom_range(0, 1)), br, $urandom,
                AW'($urandom_range(0, NR - 1)), AW'($urandom_range(0, NR - 1)));
    endtask

    function automatic void chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
        end
    endfunction

    // Monitor: compare the DUT outputs of each cycle against the queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("ready", {31'd0, ready}, {31'd0, e.rdy});
            chk("wr_conflict", {31'd0, wr_conflict}, {31'd0, e.conf});
            chk("rs1_dout", rs1_dout, e.r1);
            chk("rs2_dout", rs2_dout, e.r2);
        end
    end

    initial begin
        // Reset edge, then 32 idle clearing cycles and a full read sweep.
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd2, 5'd0);
        for (int i = 0; i < NR + 2; i++)
            step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, AW'(i), AW'(NR - 1 - i));
        for (int i = 0; i < NR; i++)
            step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, AW'(i), AW'(NR - 1 - i));

        // Basic write, x0 write dropped.
        step(1'b0, 1'b1, 5'd5, 32'hdeadbeef, 1'b0, 5'd0, 32'd0, 5'd5, 5'd0);
        step(1'b0, 1'b1, 5'd0, 32'h12345678, 1'b0, 5'd0, 32'd0, 5'd5, 5'd0);
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd5);

        // Same-index dual write: B wins, conflict pulses once.
        step(1'b0, 1'b1, 5'd7, 32'h1, 1'b1, 5'd7, 32'h2, 5'd7, 5'd7);
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd7, 5'd2);
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd7, 5'd7);

        // Same-cycle read of a port-B write, then dual write to distinct indices.
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h55, 5'd0, 5'd9);
        step(1'b0, 1'b1, 5'd10, 32'haaaa, 1'b1, 5'd11, 32'hbbbb, 5'd10, 5'd9);
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd10, 5'd11);

        for (int i = 0; i < 300; i++) rand_step(1'b0, (i % 3) == 0);

        // Reset from READY, interrupt clearing at step 10, writes during CLEAR ignored.
        rand_step(1'b1, 1'b0);
        for (int i = 0; i < 10; i++) rand_step(1'b0, 1'b0);
        rand_step(1'b1, 1'b0);
        for (int i = 0; i < NR + 2; i++) rand_step(1'b0, 1'b0);
        for (int i = 0; i < NR; i++)
            step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, AW'(i), AW'(NR - 1 - i));
        for (int i = 0; i < 100; i++) rand_step(1'b0, 1'b1);
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);

        for (int k = 0; k < 5 && exp_q.size() != 0; k++) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multiport_regfile.md
MULTIPORT_REGFILE -- requirements
Module: multiport_regfile

Interface
REQ-001 SHALL have parameter DATA_W, default 32: register width in bits.
REQ-002 SHALL have parameter NUM_REGS, default 32: register count, power of two, at least 4.
REQ-003 SHALL have parameter AW, default $clog2(NUM_REGS): register index width.
REQ-004 SHALL have parameter SP_IDX, default 2: index loaded with SP_INIT during clear.
REQ-005 SHALL have parameter SP_INIT, default 32'h2ffc: stack pointer initial value.
REQ-006 SHALL have port clk, input, 1: clock; all state updates on its rising edge.
REQ-007 SHALL have port reset, input, 1: reset, synchronous, active-high.
REQ-008 SHALL have ports rs1 and rs2, input, AW each: read indices.
REQ-009 SHALL have ports rs1_dout and rs2_dout, output, DATA_W each: read data, combinational from indices and state.
REQ-010 SHALL have ports wa_en (input, 1), wa_rd (input, AW) and wa_din (input, DATA_W): write port A.
REQ-011 SHALL have ports wb_en (input, 1), wb_rd (input, AW) and wb_din (input, DATA_W): write port B.
REQ-012 SHALL have port ready, output, 1: high once clearing completes; writes accepted only when high.
REQ-013 SHALL have port wr_conflict, output, 1: registered one-cycle pulse on a same-index dual write.

Function
REQ-014 SHALL implement a two-state FSM with states CLEAR and READY, plus clear counter idx (AW bits).
REQ-015 In CLEAR, each clock SHALL write 0 to register idx (SP_INIT if idx==SP_IDX) and increment idx.
REQ-016 CLEAR SHALL move to READY on the cycle that clears idx==NUM_REGS-1; ready SHALL be 1 from the next cycle.
REQ-017 While ready==0, rs1_dout and rs2_dout SHALL read 0, and wa_en/wb_en SHALL be ignored.
REQ-018 In READY, a write port with en==1 and rd!=0 SHALL update register rd at the clock edge; rd==0 writes SHALL be dropped.
REQ-019 Register 0 SHALL always read 0.
REQ-020 If both ports write the same nonzero rd in one cycle, port B data SHALL win.
REQ-021 On such a same-index write, wr_conflict SHALL be 1 for exactly the following cycle.
REQ-022 Both ports writing different indices in one cycle SHALL both take effect.
REQ-023 Reads SHALL be asynchronous and SHALL return stored contents, subject to REQ-017, REQ-019 and the Configuration rules.

Reset
REQ-024 While reset==1, the FSM SHALL hold state CLEAR with idx=0, ready=0 and wr_conflict=0.
REQ-025 Reset SHALL not directly modify register contents; clearing happens only through CLEAR steps.
REQ-026 Asserting reset mid-CLEAR or in READY SHALL restart clearing from idx 0.
REQ-027 ready SHALL rise exactly NUM_REGS cycles after the first clock edge with reset==0.

Configuration
REQ-028 Macro RF_BYPASS_EN SHALL control write-to-read forwarding.
REQ-029 With RF_BYPASS_EN defined, in READY, if a read index matches an enabled nonzero write rd in the same cycle, dout SHALL return that write's din, with port B taking priority over port A.
REQ-030 Without RF_BYPASS_EN, reads SHALL return the pre-edge stored value; a write becomes visible the cycle after it.

Verification
REQ-031 Reset 1 cycle, then idle -> ready=0 for 32 cycles, then 1; x0-x31 read 0 except x2=32'h00002ffc.
REQ-032 READY: wa writes x5=32'hdeadbeef -> next cycle rs1=5 reads 32'hdeadbeef; wa_rd=0 write leaves x0 reading 0.
REQ-033 READY: wa x7=32'h1 and wb x7=32'h2 in the same cycle -> x7 reads 32'h2 and wr_conflict pulses 1 for one cycle.
REQ-034 rs2=9 while wb writes x9=32'h55 -> rs2_dout=32'h55 in the same cycle with RF_BYPASS_EN, old value without it.
REQ-035 Reset asserted at clear step 10 -> idx restarts at 0 and ready rises 32 cycles after reset drops; wa_en pulses during CLEAR have no effect.
